// File: rtl/exc_controller.sv
// Exception entry/exit sequencer: collects invalid-opcode and external IRQ events,
// prioritises them, and handshakes Exc/EStatus with the datapath through RAISE/HANDLER.
module exc_controller #(
  parameter int unsigned NIRQ        = 2,
  parameter int unsigned ACK_TIMEOUT = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            invalid_op,
  input  logic [NIRQ-1:0] ext_irq,
  input  logic [NIRQ-1:0] irq_en,
  input  logic            ERet,
  input  logic            ExcAck,
  output logic            Exc,
  output logic [3:0]      EStatus,
  output logic            busy,
  output logic [NIRQ:0]   pending,
  output logic [7:0]      lost_cnt,
  output logic            err_timeout,
  output logic            double_fault
);

  localparam int unsigned NSRC = NIRQ + 1;
  localparam int unsigned IDXW = 4;
  localparam int unsigned TW   = $clog2(ACK_TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RAISE   = 2'd1;
  localparam logic [1:0] ST_HANDLER = 2'd2;

  logic [1:0]      state_q,   state_d;
  logic [NIRQ-1:0] sync1_q,   sync2_q, sync3_q;
  logic [NIRQ:0]   pending_q, pending_d;
  logic [IDXW-1:0] sel_q,     sel_d;
  logic [3:0]      estatus_q, estatus_d;
  logic [TW-1:0]   timer_q,   timer_d;
  logic [7:0]      lost_q,    lost_d;
  logic            err_to_q,  err_to_d;
  logic            dfault_q,  dfault_d;

  logic [NIRQ:0]   set_vec, clr_vec, eligible;
  logic [IDXW-1:0] win_idx, lost_inc;
  logic            win_vld, ack;
  logic [8:0]      lost_sum;

  // Synchroniser plus edge-history flop per IRQ line
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
    end else begin
      sync1_q <= ext_irq;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      sel_q     <= '0;
      estatus_q <= '0;
      timer_q   <= '0;
      lost_q    <= '0;
      err_to_q  <= 1'b0;
      dfault_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      sel_q     <= sel_d;
      estatus_q <= estatus_d;
      timer_q   <= timer_d;
      lost_q    <= lost_d;
      err_to_q  <= err_to_d;
      dfault_q  <= dfault_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    estatus_d = estatus_q;
    timer_d   = timer_q;
    err_to_d  = err_to_q;
    dfault_d  = dfault_q;
    win_idx   = '0;
    lost_inc  = '0;
    clr_vec   = '0;

    set_vec  = {sync2_q & ~sync3_q, invalid_op};
    eligible = pending_q & {irq_en, 1'b1};
    win_vld  = |eligible;
    // Lowest eligible index has highest priority
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (eligible[i]) win_idx = IDXW'(i);
    end

    ack = (state_q == ST_RAISE) && ExcAck;
    for (int i = 0; i < NSRC; i++) begin
      clr_vec[i] = ack && (sel_q == IDXW'(i));
    end
    // A new event on the clearing cycle re-arms the bit and is not a loss
    pending_d = (pending_q & ~clr_vec) | set_vec;

    for (int i = 0; i < NSRC; i++) begin
      lost_inc = lost_inc + IDXW'(set_vec[i] & pending_q[i] & ~clr_vec[i]);
    end
    lost_sum = 9'(lost_q) + 9'(lost_inc);
    lost_d   = (lost_sum > 9'd255) ? 8'hFF : lost_sum[7:0];

    case (state_q)
      ST_IDLE: begin
        estatus_d = 4'd0;
        if (win_vld) begin
          state_d   = ST_RAISE;
          sel_d     = win_idx;
          estatus_d = win_idx + 4'd1;
          timer_d   = TW'(ACK_TIMEOUT);
        end
      end
      ST_RAISE: begin
        if (ExcAck) begin
          state_d = ST_HANDLER;
        end else if (timer_q <= TW'(1)) begin
          state_d   = ST_IDLE;
          estatus_d = 4'd0;
          err_to_d  = 1'b1;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      ST_HANDLER: begin
        if (invalid_op) dfault_d = 1'b1;
        if (ERet) begin
          state_d   = ST_IDLE;
          estatus_d = 4'd0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        estatus_d = 4'd0;
      end
    endcase
  end

  assign Exc          = (state_q == ST_RAISE);
  assign busy         = (state_q != ST_IDLE);
  assign EStatus      = estatus_q;
  assign pending      = pending_q;
  assign lost_cnt     = lost_q;
  assign err_timeout  = err_to_q;
  assign double_fault = dfault_q;

endmodule
